// File: rtl/des_pkg.sv
// Shared tables, state type and helpers for the DES key schedule.
package des_pkg;

  localparam int NUM_ROUNDS = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // PC-1: 1-based source bit (1 = key MSB) for each of the 56 outputs, MSB first.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: 1-based source bit of {C,D} (1 = C MSB) for each of the 48 outputs.
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Per-round left-shift amounts; entry 0 is the shift for round 1.
  localparam int SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[6'(55 - i)] = key[6'(64 - PC1_TAB[i])];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    return (n == 2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
    return (n == 2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression permutation: 56-bit {C,D} down to a 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd_i,
  output logic [47:0] subkey_o
);

  // Pure bit selection driven by the package table.
  always_comb begin
    subkey_o = '0;
    for (int i = 0; i < 48; i++) begin
      subkey_o[6'(47 - i)] = cd_i[6'(56 - PC2_TAB[i])];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: emits K1..K16 (encrypt) or K16..K1 (decrypt)
// one subkey per valid/ready handshake.
module des_key_schedule
  import des_pkg::*;
#(
  parameter bit ZERO_WHEN_IDLE = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS - 1);

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dec_q, dec_d;
  logic        done_q, done_d;
  logic [55:0] key_pc1;
  logic [47:0] pc2_out;

  assign key_pc1 = pc1(key);

  // State and key-register update, cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
    end
  end

  // Load on start, step the rotation after each accepted subkey.
  // Decrypt walks the encrypt rotations backwards, so it undoes the shift
  // that led into the current round.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dec_d   = decrypt;
          cnt_d   = '0;
          state_d = RUN;
          if (decrypt) begin
            c_d = key_pc1[55:28];
            d_d = key_pc1[27:0];
          end else begin
            c_d = rotl28(key_pc1[55:28], SHIFT_TAB[0]);
            d_d = rotl28(key_pc1[27:0], SHIFT_TAB[0]);
          end
        end
      end
      RUN: begin
        if (subkey_ready) begin
          if (cnt_q == LAST_CNT) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
            if (dec_q) begin
              c_d = rotr28(c_q, SHIFT_TAB[15 - int'(cnt_q)]);
              d_d = rotr28(d_q, SHIFT_TAB[15 - int'(cnt_q)]);
            end else begin
              c_d = rotl28(c_q, SHIFT_TAB[int'(cnt_q) + 1]);
              d_d = rotl28(d_q, SHIFT_TAB[int'(cnt_q) + 1]);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  des_pc2 u_pc2 (
    .cd_i     ({c_q, d_q}),
    .subkey_o (pc2_out)
  );

  assign subkey_valid = (state_q == RUN);
  assign busy         = (state_q == RUN);
  assign done         = done_q;
  assign round        = subkey_valid ? (dec_q ? (LAST_CNT - cnt_q) : cnt_q) : 4'd0;
  assign subkey       = (ZERO_WHEN_IDLE && !subkey_valid) ? 48'd0 : pc2_out;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule with an independent subkey model.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        decrypt;
  logic [63:0] key;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] KEY_KAT = 64'h133457799BBCDFF1;
  localparam logic [47:0] KAT_K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] KAT_K2  = 48'h79AED9DBC9E5;
  localparam logic [47:0] KAT_K16 = 48'hCB3D8B0E17F5;

  localparam int M_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int M_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int M_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic [47:0] exp_k [16];
  logic [47:0] got_k [16];
  logic [47:0] enc_k [16];

  always #5 clk = ~clk;

  des_key_schedule #(.ZERO_WHEN_IDLE(1'b1)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .decrypt      (decrypt),
    .key          (key),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round        (round),
    .busy         (busy),
    .done         (done)
  );

  function automatic logic [27:0] rot_left(input logic [27:0] x, input int t);
    logic [55:0] y;
    y = {x, x};
    return y[6'(55 - t) -: 28];
  endfunction

  // Kn = PC2(C0 <<< sum(S[1..n]), D0 <<< sum(S[1..n])).
  task automatic model_keys(input logic [63:0] k);
    logic [27:0] c0, d0;
    logic [55:0] cd;
    int t;
    for (int i = 0; i < 28; i++) begin
      c0[5'(27 - i)] = k[6'(64 - M_PC1[i])];
      d0[5'(27 - i)] = k[6'(64 - M_PC1[28 + i])];
    end
    t = 0;
    for (int n = 0; n < 16; n++) begin
      t += M_SHIFT[n];
      cd = {rot_left(c0, t % 28), rot_left(d0, t % 28)};
      for (int j = 0; j < 48; j++) exp_k[n][6'(47 - j)] = cd[6'(56 - M_PC2[j])];
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic run_sched(input logic [63:0] k, input bit dec, input bit rnd_ready,
                           input bit poke_start);
    int hs, cyc, stall, idx;
    logic [47:0] prev_sub;
    logic [3:0]  prev_rnd;
    bit          was_stalled;
    model_keys(k);
    key = k; decrypt = dec; start = 1'b1; subkey_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (subkey_valid !== 1'b1) begin
      n_fail++; $display("FAIL latency_valid: got %b want 1", subkey_valid);
    end
    hs = 0; cyc = 0; stall = 0; was_stalled = 1'b0;
    prev_sub = '0; prev_rnd = '0;
    while (hs < 16 && cyc < 500) begin
      idx = dec ? 15 - hs : hs;
      n_checks++;
      if (subkey_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL run_flags hs=%0d: valid=%b busy=%b done=%b want 1 1 0",
                 hs, subkey_valid, busy, done);
      end
      n_checks++;
      if (subkey !== exp_k[idx]) begin
        n_fail++; $display("FAIL subkey hs=%0d: got %h want %h", hs, subkey, exp_k[idx]);
      end
      n_checks++;
      if (round !== 4'(idx)) begin
        n_fail++; $display("FAIL round hs=%0d: got %0d want %0d", hs, round, idx);
      end
      if (was_stalled) begin
        n_checks++;
        if (subkey !== prev_sub || round !== prev_rnd) begin
          n_fail++;
          $display("FAIL stall_hold hs=%0d: got %h/%0d want %h/%0d",
                   hs, subkey, round, prev_sub, prev_rnd);
        end
      end
      got_k[hs] = subkey;
      if (poke_start && hs == 5) begin
        start = 1'b1; key = 64'd0; decrypt = ~dec;
      end else begin
        start = 1'b0; key = k; decrypt = dec;
      end
      if (rnd_ready) begin
        if (hs == 2 && stall < 5) begin
          subkey_ready = 1'b0; stall++;
        end else begin
          subkey_ready = ($urandom_range(0, 2) != 0);
        end
      end else begin
        subkey_ready = 1'b1;
      end
      prev_sub = subkey; prev_rnd = round; was_stalled = !subkey_ready;
      if (subkey_ready) hs++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; key = k; decrypt = dec; subkey_ready = 1'b0;
    n_checks++;
    if (cyc >= 500) begin
      n_fail++; $display("FAIL handshake_timeout: got %0d handshakes want 16", hs);
    end
    n_checks++;
    if (done !== 1'b1 || subkey_valid !== 1'b0 || busy !== 1'b0 ||
        subkey !== 48'd0 || round !== 4'd0) begin
      n_fail++;
      $display("FAIL done_cycle: done=%b valid=%b busy=%b subkey=%h round=%0d want 1 0 0 0 0",
               done, subkey_valid, busy, subkey, round);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; decrypt = 1'b0; subkey_ready = 1'b0;
    key = {$urandom, $urandom};
    repeat (2) @(negedge clk);
    n_checks++;
    if (subkey !== 48'd0 || subkey_valid !== 1'b0 || round !== 4'd0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: subkey=%h valid=%b round=%0d busy=%b done=%b want all 0",
               subkey, subkey_valid, round, busy, done);
    end
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      key = {$urandom, $urandom};
      @(negedge clk);
      n_checks++;
      if (subkey !== 48'd0 || subkey_valid !== 1'b0 || round !== 4'd0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_outputs: subkey=%h valid=%b round=%0d done=%b want all 0",
                 subkey, subkey_valid, round, done);
      end
    end
  endtask

  task automatic test_encrypt();
    run_sched(KEY_KAT, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) enc_k[i] = got_k[i];
    n_checks++;
    if (got_k[0] !== KAT_K1 || got_k[1] !== KAT_K2 || got_k[15] !== KAT_K16) begin
      n_fail++;
      $display("FAIL enc_kat: got %h %h %h want %h %h %h",
               got_k[0], got_k[1], got_k[15], KAT_K1, KAT_K2, KAT_K16);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || subkey !== 48'd0) begin
      n_fail++; $display("FAIL done_pulse_width: done=%b subkey=%h want 0 0", done, subkey);
    end
  endtask

  task automatic test_decrypt();
    run_sched(KEY_KAT, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (got_k[0] !== KAT_K16 || got_k[15] !== KAT_K1) begin
      n_fail++;
      $display("FAIL dec_kat: got %h %h want %h %h", got_k[0], got_k[15], KAT_K16, KAT_K1);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (got_k[i] !== enc_k[15 - i]) begin
        n_fail++; $display("FAIL dec_reverse i=%0d: got %h want %h", i, got_k[i], enc_k[15 - i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    for (int n = 0; n < 4; n++) begin
      run_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    run_sched(KEY_KAT, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (got_k[i] !== enc_k[i]) begin
        n_fail++; $display("FAIL start_ignored i=%0d: got %h want %h", i, got_k[i], enc_k[i]);
      end
    end
    run_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_midreset();
    int hs, cyc;
    key = KEY_KAT; decrypt = 1'b0; start = 1'b1; subkey_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 7 && cyc < 100) begin
      if (subkey_valid === 1'b1) hs++;
      cyc++;
      @(negedge clk);
    end
    n_checks++;
    if (hs != 7) begin
      n_fail++; $display("FAIL midreset_progress: got %0d handshakes want 7", hs);
    end
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if (subkey !== 48'd0 || subkey_valid !== 1'b0 || round !== 4'd0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: subkey=%h valid=%b round=%0d busy=%b done=%b want all 0",
               subkey, subkey_valid, round, busy, done);
    end
    subkey_ready = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || subkey_valid !== 1'b0) begin
        n_fail++; $display("FAIL no_done_after_abort: done=%b valid=%b want 0 0", done, subkey_valid);
      end
    end
    run_sched(KEY_KAT, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (got_k[0] !== KAT_K1) begin
      n_fail++; $display("FAIL restart_k1: got %h want %h", got_k[0], KAT_K1);
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_start_ignored();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
Iterative DES key-schedule generator and the producer side of the round function's `subkey` input.
- Takes a 64-bit DES key.
- Emits the sixteen 48-bit round subkeys one at a time over a valid/ready handshake.
- Order is K1..K16 for encryption, K16..K1 for decryption.
- Sits between the top-level control and the round/Ffunction datapath.

Parameters:
- ZERO_WHEN_IDLE, 1, when 1 `subkey` is driven 0 whenever `subkey_valid` is low; when 0 it shows PC-2 of the current C/D registers.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  request a new schedule; sampled only in IDLE.
- decrypt  input  1  0 = K1..K16 order, 1 = K16..K1 order; sampled with `start`.
- key  input  64  DES key, bit 1 = MSB, parity bits ignored; sampled with `start`.
- subkey  output  48  current round subkey, bit 1 = MSB.
- subkey_valid  output  1  `subkey` holds a valid round key.
- subkey_ready  input  1  consumer accepts `subkey` this cycle.
- round  output  4  index of emitted key minus 1 (K1 -> 0, K16 -> 15); 0 when idle.
- busy  output  1  high from the cycle after `start` is accepted until the final handshake.
- done  output  1  one-cycle pulse the cycle after the 16th handshake.

Behaviour:
- Reset (asynchronous, rstn = 0): state IDLE, C = D = 0, count = 0, and every output 0 (`subkey`, `subkey_valid`, `round`, `busy`, `done`).
- A reset during RUN aborts the schedule immediately. No `done` is produced.
- Registers: 28-bit C and D, 4-bit emission counter `cnt` (0..15), mode flag `dec`, state {IDLE, RUN}.
- Shift table S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Total rotation is 28, so C16 = C0.
- IDLE with start = 1:
  - {C,D} <= PC1(key); `dec` <= decrypt; `cnt` <= 0; go to RUN.
  - Encrypt: C and D are additionally rotated left by S[1] in the same load.
  - Decrypt: no rotation at load, since K16 = PC2(C0,D0).
- Latency: `subkey_valid` = 1 exactly one cycle after start is sampled.
- RUN:
  - `subkey_valid` = 1 and `subkey` = PC2({C,D}), driven combinationally from the registers.
  - `round` = cnt when dec = 0, and 15 - cnt when dec = 1.
- Handshake: `subkey` and `round` must hold stable while valid = 1 and ready = 0. Arbitrary stalls are allowed.
- On valid and ready with cnt < 15:
  - cnt++.
  - Encrypt: rotate C and D left by S[cnt+2], which is the shift of the next round.
  - Decrypt: rotate C and D right by S[16-cnt], so K16 -> K15 uses S[16] = 1 and K2 -> K1 uses S[2] = 1.
- On valid and ready with cnt = 15: go to IDLE; `subkey_valid` and `busy` fall; `done` = 1 for one cycle; cnt <= 0.
- `start` while in RUN is ignored; `key` and `decrypt` may change freely without effect.
- `start` is accepted in the same cycle `done` is high (state is IDLE), allowing back-to-back schedules with no bubble beyond the `done` cycle.
- Rotations are 28-bit circular, applied independently to C and D.
- PC-1 uses standard DES bit numbering: 56 of the 64 bits; bits 8, 16, ..., 64 are dropped.

Decomposition:
- Package `des_pkg`:
  - PC1 table (56 entries) and PC2 table (48 entries), 1-based MSB-first indices.
  - Shift table S[1..16].
  - State enum {IDLE, RUN}.
  - Constant NUM_ROUNDS = 16.
- One combinational sub-module, `des_pc2`: 56-bit {C,D} in, 48-bit subkey out, table-driven from `des_pkg`.
- PC-1 and the rotations stay inline.

Test Plan:
- Encrypt order: key 0x133457799BBCDFF1, decrypt = 0, ready tied 1 -> valid one cycle after start; K1 = 0x1B02EFFC7072 (round 0), K2 = 0x79AED9DBC9E5 (round 1), ..., K16 = 0xCB3D8B0E17F5 (round 15); `done` pulses the cycle after K16.
- Decrypt order: same key, decrypt = 1 -> first subkey 0xCB3D8B0E17F5 with round = 15, second equals encrypt-order K15, last 0x1B02EFFC7072 with round = 0. All 16 values equal the reversed encrypt sequence.
- Backpressure: hold ready = 0 for 5 cycles on K3, and toggle ready randomly elsewhere -> `subkey` and `round` stable during stalls; exactly 16 handshakes occur with correct values.
- Start/key ignored while busy: pulse start with key 0 and decrypt toggled mid-schedule -> sequence unchanged. Then start in the `done` cycle -> new schedule begins, valid high on the next cycle.
- Mid-operation reset: assert rstn = 0 asynchronously after K7 -> all outputs 0 immediately, no `done`. After release, a fresh start reproduces K1 = 0x1B02EFFC7072.
- Idle output: with ZERO_WHEN_IDLE = 1, `subkey` = 0 whenever valid = 0, including before the first start and in the `done` cycle.
